snap_trig_ctrl: RTL and testbench
=================================

# snap_trig_ctrl

Snapshot trigger/capture controller fed directly by the 32-bit `testing_snap_trig` software register (`user_data_out`). It decodes the control word to arm, trigger, delay and abort a snapshot capture. It then writes a burst of `2**ADDR_W` valid samples into the snapshot BRAM and reports completion and fill count for software readback. All logic runs in the `user_clk` domain, the same domain in which the register's output is already synchronous, so no CDC is needed.

## Interface
Parameters:
- `ADDR_W`, default 10: BRAM address width; capture length is `2**ADDR_W` samples.
- `DATA_W`, default 32: sample width.

Ports:
- `user_clk`, in, 1: sole clock.
- `user_rst_n`, in, 1: reset, asynchronous, active-low.
- `ctrl_word`, in, 32: software register value.
  - Bit 0: arm. Its rising edge arms the capture.
  - Bit 1: manual trigger select. 1 = trigger on the first valid sample; 0 = use `trig_in`.
  - Bit 2: abort (level).
  - Bits 31:16: trigger delay `D`, counted in valid samples.
- `din`, in, `DATA_W`: sample data.
- `din_valid`, in, 1: sample strobe.
- `trig_in`, in, 1: external trigger (level), qualified by `din_valid`.
- `bram_addr`, out, `ADDR_W`: snapshot BRAM write address.
- `bram_data`, out, `DATA_W`: snapshot BRAM write data.
- `bram_we`, out, 1: snapshot BRAM write enable.
- `busy`, out, 1: high in ARMED, DELAY or CAPTURE.
- `done`, out, 1: capture complete; held until the next arm or abort.
- `count`, out, `ADDR_W+1`: number of samples written in the current capture.

## Operation
- An arm edge is `ctrl_word[0]` high this cycle and low in the registered previous-cycle copy.
- States are IDLE, ARMED, DELAY, CAPTURE and DONE. Reset forces IDLE.
- Abort (`ctrl_word[2]` = 1) has priority over everything else.
  - From any state, it goes to IDLE on the next edge.
  - It clears `done` and `count` and forces `bram_we` to 0.
  - Arm edges are ignored while abort is high.
- IDLE or DONE, on an arm edge: go to ARMED. Clear `done`, `count` and the address.
- ARMED: the trigger is a cycle with `din_valid`=1 and (`ctrl_word[1]`=1 or `trig_in`=1).
  - If `D`=0, go to CAPTURE. The triggering sample is written at address 0.
  - If `D`>0, go to DELAY and load the delay counter with `D`. The triggering sample is discarded.
- DELAY: each valid sample decrements the counter and is discarded.
  - The valid sample that brings the counter to 0 is also discarded, and the state moves to CAPTURE.
  - The first written sample is therefore the (`D`+1)-th valid sample after the trigger sample.
- CAPTURE: each valid sample is written at the current address, then the address and `count` increment.
  - After the write at address `2**ADDR_W-1`, go to DONE and set `done`=1.
  - `count` = `2**ADDR_W` in DONE. The address wraps to 0 but no further writes occur.
- Cycles with `din_valid`=0 change nothing: no write, and counters hold in every state.
- `trig_in` outside ARMED is ignored. Arm edges in ARMED, DELAY or CAPTURE are ignored (no restart).
- `D` is sampled only on the trigger cycle. Later changes to `ctrl_word[31:16]` do not affect the capture in progress.
- `ctrl_word[1]` is read only in ARMED.

## Timing
- Reset values: state IDLE, `bram_we`=0, `bram_addr`=0, `bram_data`=0, `busy`=0, `done`=0, `count`=0, previous arm bit=0.
- Reset mid-capture aborts immediately and asynchronously to these values. No further writes occur after reset.
- All outputs are registered.
  - A sample accepted at edge N appears on `bram_we`/`bram_addr`/`bram_data` in the cycle after edge N, so latency is 1 cycle.
  - `count` updates on the same edge as its write.
- Arm-edge latency: `busy` rises 1 cycle after the cycle in which `ctrl_word[0]` rises.
- `done` rises on the same edge that issues the final `bram_we`. `busy` falls on that edge.
- Back-to-back valid samples are written every cycle without stalls. Maximum throughput is 1 sample per clock.

## Test plan
- Immediate trigger, `D`=0, `ADDR_W`=4, continuous valid with `din`=0..:
  - Arm gives 16 writes of `din` 0..15 at addresses 0..15.
  - `done`=1 and `count`=16.
- External trigger, `D`=3: `trig_in` pulses on the valid sample with `din`=100.
  - The first write is `din`=104 at address 0.
  - No writes occur before the trigger.
- `din_valid` toggles 1/0 during CAPTURE: writes occur only on valid cycles, addresses stay contiguous, and `count` holds on invalid cycles.
- Abort asserted mid-CAPTURE at address 7:
  - Next cycle `bram_we`=0, `busy`=0 and `count`=0.
  - A re-arm then restarts the capture at address 0.
- Arm edge during CAPTURE is ignored. Arm edge in DONE clears `done` and captures again.
- `user_rst_n` pulsed low mid-DELAY: all outputs go to 0 immediately, the state returns to IDLE, and the previous arm bit clears.
  - With `ctrl_word[0]` held at 1 through reset, the block re-arms on the first clock after reset release.

Source files
------------

// File: rtl/snap_trig_ctrl.sv
// Snapshot trigger/capture controller: decodes the software control word to arm,
// trigger, delay and abort a capture, then writes 2**ADDR_W valid samples into the snapshot BRAM.
module snap_trig_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl_word,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              trig_in,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_arm_prev;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_delay;

  logic        w_arm_edge;
  logic        w_abort;
  logic        w_trig;
  logic        w_last;
  logic [15:0] w_delay_in;

  assign w_arm_edge = ctrl_word[0] & ~r_arm_prev;
  assign w_abort    = ctrl_word[2];
  assign w_trig     = din_valid & (ctrl_word[1] | trig_in);
  assign w_delay_in = ctrl_word[31:16];
  assign w_last     = (r_addr == {ADDR_W{1'b1}});

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_state    <= S_IDLE;
      r_arm_prev <= 1'b0;
      r_addr     <= '0;
      r_delay    <= '0;
      bram_addr  <= '0;
      bram_data  <= '0;
      bram_we    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
    end else begin
      r_arm_prev <= ctrl_word[0];
      bram_we    <= 1'b0;
      if (w_abort) begin
        r_state <= S_IDLE;
        r_addr  <= '0;
        busy    <= 1'b0;
        done    <= 1'b0;
        count   <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (w_arm_edge) begin
              r_state <= S_ARMED;
              r_addr  <= '0;
              busy    <= 1'b1;
              done    <= 1'b0;
              count   <= '0;
            end
          end
          S_ARMED: begin
            // With zero delay the trigger sample itself is the first one stored
            if (w_trig) begin
              if (w_delay_in == 16'd0) begin
                bram_we   <= 1'b1;
                bram_addr <= r_addr;
                bram_data <= din;
                r_addr    <= r_addr + 1'b1;
                count     <= count + 1'b1;
                r_state   <= S_CAPTURE;
              end else begin
                r_delay <= w_delay_in;
                r_state <= S_DELAY;
              end
            end
          end
          S_DELAY: begin
            if (din_valid) begin
              r_delay <= r_delay - 16'd1;
              if (r_delay == 16'd1) r_state <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (din_valid) begin
              bram_we   <= 1'b1;
              bram_addr <= r_addr;
              bram_data <= din;
              r_addr    <= r_addr + 1'b1;
              count     <= count + 1'b1;
              if (w_last) begin
                r_state <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snap_trig_ctrl.sv
// Bench for snap_trig_ctrl: a hand-computed vector table, directed corner sequences and
// randomized traffic checked against a sample-index model of the capture window.
module tb_snap_trig_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int N  = 1 << AW;

  logic          user_clk = 1'b0;
  logic          user_rst_n;
  logic [31:0]   ctrl_word;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          trig_in;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_data;
  logic          bram_we;
  logic          busy;
  logic          done;
  logic [AW:0]   count;

  snap_trig_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .user_clk(user_clk), .user_rst_n(user_rst_n), .ctrl_word(ctrl_word),
    .din(din), .din_valid(din_valid), .trig_in(trig_in),
    .bram_addr(bram_addr), .bram_data(bram_data), .bram_we(bram_we),
    .busy(busy), .done(done), .count(count)
  );

  always #5 user_clk = ~user_clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: after a trigger, valid samples are numbered n = 0,1,2...; sample n is
  // stored at address n - first, where first is 0 for D=0 and D+1 otherwise.
  bit        m_prev, m_armed, m_trig, m_done;
  int        m_n, m_first, m_cnt;
  bit        e_we;
  int        e_addr;
  logic [31:0] e_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_armed = 0; m_trig = 0; m_done = 0; m_cnt = 0; m_n = 0; m_first = 0;
    e_we = 0;
  endtask

  task automatic take_sample(input logic [31:0] d);
    if (m_n >= m_first) begin
      e_we = 1; e_addr = m_n - m_first; e_data = d; m_cnt++;
      if (m_cnt == N) begin m_trig = 0; m_done = 1; end
    end
  endtask

  task automatic model_step(input logic [31:0] c, input logic v, input logic t, input logic [31:0] d);
    e_we = 0;
    if (c[2]) begin
      m_armed = 0; m_trig = 0; m_done = 0; m_cnt = 0;
    end else if (!m_armed && !m_trig) begin
      if (c[0] && !m_prev) begin m_armed = 1; m_done = 0; m_cnt = 0; end
    end else if (m_armed) begin
      if (v && (c[1] || t)) begin
        m_armed = 0; m_trig = 1; m_n = 0;
        m_first = (c[31:16] == 16'd0) ? 0 : int'(c[31:16]) + 1;
        take_sample(d);
      end
    end else if (v) begin
      m_n++;
      take_sample(d);
    end
    m_prev = c[0];
  endtask

  task automatic check_model(input string tag);
    check({tag, "_we"}, {31'd0, bram_we}, {31'd0, e_we});
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, (m_armed | m_trig)});
    check({tag, "_done"}, {31'd0, done}, {31'd0, m_done});
    check({tag, "_count"}, 32'(count), 32'(m_cnt));
    if (e_we) begin
      check({tag, "_addr"}, 32'(bram_addr), 32'(e_addr));
      check({tag, "_data"}, bram_data, e_data);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] c, input logic v, input logic t, input logic [31:0] d);
    ctrl_word = c; din_valid = v; trig_in = t; din = d;
    @(posedge user_clk);
    model_step(c, v, t, d);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic [31:0] ctrl;
    logic        valid;
    logic        trig;
    logic [31:0] din;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic [4:0]  cnt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Arm with D=2 and external trigger; trigger on din=6, 7 and 8 discarded, 9 stored first
    tbl[0]  = '{32'h0000_0000, 0, 0, 32'd4,  0, 4'd0, 32'd0,  0, 0, 5'd0};
    tbl[1]  = '{32'h0002_0001, 0, 0, 32'd4,  0, 4'd0, 32'd0,  1, 0, 5'd0};
    tbl[2]  = '{32'h0002_0001, 1, 0, 32'd5,  0, 4'd0, 32'd0,  1, 0, 5'd0};
    tbl[3]  = '{32'h0002_0001, 1, 1, 32'd6,  0, 4'd0, 32'd0,  1, 0, 5'd0};
    tbl[4]  = '{32'h0002_0001, 0, 0, 32'd99, 0, 4'd0, 32'd0,  1, 0, 5'd0};
    tbl[5]  = '{32'h0002_0001, 1, 0, 32'd7,  0, 4'd0, 32'd0,  1, 0, 5'd0};
    tbl[6]  = '{32'h0002_0001, 1, 0, 32'd8,  0, 4'd0, 32'd0,  1, 0, 5'd0};
    tbl[7]  = '{32'h0002_0001, 1, 0, 32'd9,  1, 4'd0, 32'd9,  1, 0, 5'd1};
    tbl[8]  = '{32'h0002_0001, 0, 0, 32'd10, 0, 4'd0, 32'd0,  1, 0, 5'd1};
    tbl[9]  = '{32'h0002_0001, 1, 0, 32'd11, 1, 4'd1, 32'd11, 1, 0, 5'd2};
    tbl[10] = '{32'h0000_0004, 1, 0, 32'd12, 0, 4'd0, 32'd0,  0, 0, 5'd0};

    user_rst_n = 0; ctrl_word = 0; din = 0; din_valid = 0; trig_in = 0;
    model_reset();
    repeat (2) @(posedge user_clk);
    #1;
    check("rst_we", {31'd0, bram_we}, 32'd0);
    check("rst_addr", 32'(bram_addr), 32'd0);
    check("rst_data", bram_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    #3 user_rst_n = 1;

    for (int i = 0; i < 11; i++) begin
      ctrl_word = tbl[i].ctrl; din_valid = tbl[i].valid; trig_in = tbl[i].trig; din = tbl[i].din;
      @(posedge user_clk);
      model_step(tbl[i].ctrl, tbl[i].valid, tbl[i].trig, tbl[i].din);
      #1;
      check($sformatf("tbl%0d_we", i), {31'd0, bram_we}, {31'd0, tbl[i].we});
      check($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
      check($sformatf("tbl%0d_done", i), {31'd0, done}, {31'd0, tbl[i].done});
      check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      if (tbl[i].we) begin
        check($sformatf("tbl%0d_addr", i), 32'(bram_addr), 32'(tbl[i].addr));
        check($sformatf("tbl%0d_data", i), bram_data, tbl[i].data);
      end
    end

    // Immediate trigger, D=0, continuous valid 0..15
    step("imm", 32'h0, 0, 0, 0);
    step("imm", 32'h3, 0, 0, 0);
    for (int i = 0; i < N; i++) step("imm", 32'h3, 1, 0, i);
    check("imm_done", {31'd0, done}, 32'd1);
    check("imm_count", 32'(count), 32'd16);
    check("imm_lastaddr", 32'(bram_addr), 32'd15);
    step("imm_post", 32'h3, 1, 0, 77);

    // External trigger with D=3 on din=100, then valid toggling during capture
    step("ext", 32'h0003_0000, 0, 0, 0);
    step("ext", 32'h0003_0001, 0, 0, 0);
    step("ext", 32'h0003_0001, 1, 0, 98);
    step("ext", 32'h0003_0001, 1, 0, 99);
    step("ext", 32'h0003_0001, 1, 1, 100);
    for (int i = 101; i <= 104; i++) step("ext", 32'h0009_0001, 1, (i == 102), i);
    check("ext_first_we", {31'd0, bram_we}, 32'd1);
    check("ext_first_data", bram_data, 32'd104);
    check("ext_first_addr", 32'(bram_addr), 32'd0);
    for (int i = 0; i < 12; i++) step("tog", 32'h0000_0001, i[0], 0, 200 + i);
    // Arm edge during capture must not restart it
    step("rearm_cap", 32'h0, 1, 0, 300);
    step("rearm_cap", 32'h1, 1, 0, 301);
    for (int i = 0; i < 12; i++) step("fin", 32'h1, 1, 0, 310 + i);
    check("fin_done", {31'd0, done}, 32'd1);
    // Arm edge in DONE clears done and captures again
    step("redone", 32'h2, 0, 0, 0);
    step("redone", 32'h3, 0, 0, 0);
    check("redone_done", {31'd0, done}, 32'd0);

    // Abort right after the write at address 7, then re-arm
    for (int i = 0; i < 8; i++) step("abt", 32'h3, 1, 0, 400 + i);
    check("abt_addr7", 32'(bram_addr), 32'd7);
    step("abt", 32'h7, 1, 0, 500);
    check("abt_we", {31'd0, bram_we}, 32'd0);
    check("abt_busy", {31'd0, busy}, 32'd0);
    check("abt_count", 32'(count), 32'd0);
    step("abt_re", 32'h0, 0, 0, 0);
    step("abt_re", 32'h3, 0, 0, 0);
    step("abt_re", 32'h3, 1, 0, 600);
    check("abt_re_addr", 32'(bram_addr), 32'd0);
    check("abt_re_data", bram_data, 32'd600);

    // Asynchronous reset in the middle of DELAY, arm bit held through it
    step("rd", 32'h4, 0, 0, 0);
    step("rd", 32'h0005_0001, 0, 0, 0);
    step("rd", 32'h0005_0001, 1, 1, 700);
    step("rd", 32'h0005_0001, 1, 0, 701);
    #2 user_rst_n = 0;
    #1;
    check("rd_busy", {31'd0, busy}, 32'd0);
    check("rd_we", {31'd0, bram_we}, 32'd0);
    check("rd_count", 32'(count), 32'd0);
    check("rd_addr", 32'(bram_addr), 32'd0);
    check("rd_data", bram_data, 32'd0);
    model_reset();
    ctrl_word = 32'h1;
    @(posedge user_clk);
    #2 user_rst_n = 1;
    step("rd_rearm", 32'h1, 0, 0, 0);
    check("rd_rearm_busy", {31'd0, busy}, 32'd1);
    step("rd_clr", 32'h4, 0, 0, 0);

    // Randomized traffic
    begin
      logic [31:0] c;
      c = 32'h0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) c[0] = ~c[0];
        if ($urandom_range(0, 15) == 0) c[1] = ~c[1];
        c[2] = ($urandom_range(0, 79) == 0);
        c[31:16] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom_range(0, 2));
        step("rnd", c, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
